// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution slice.
// Contents:
//   OP_*   RV32/RV64 major opcodes for conditional branches, JAL and JALR
//   F3_*   funct3 encodings of the six conditional branches and of JALR
//   state_t flush sequencer state (IDLE, FLUSH)
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_BLT    = 3'b100;
  localparam logic [2:0] F3_BGE    = 3'b101;
  localparam logic [2:0] F3_BLTU   = 3'b110;
  localparam logic [2:0] F3_BGEU   = 3'b111;
  localparam logic [2:0] F3_JALR   = 3'b000;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator for branch resolution (purely combinational).
// Ports:
//   rs1, rs2  in  XLEN  source operands
//   eq        out 1     rs1 == rs2
//   lt        out 1     rs1 <  rs2, two's-complement signed
//   ltu       out 1     rs1 <  rs2, unsigned
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: decodes BEQ..BGEU/JAL/JALR, compares operands,
// computes the target, checks against the fetch prediction, registers the result
// (1-cycle latency), sequences a FLUSH_DEPTH-cycle flush on mispredict and keeps
// saturating taken/mispredict statistics.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   ex_valid, stall       candidate valid; stall freezes outputs and flush countdown
//   op_funct              {funct3, opcode}
//   rs1_val, rs2_val      source operands
//   pc, imm               candidate PC and sign-extended immediate
//   pred_taken            fetch direction prediction
//   br_valid/taken/target registered resolution
//   misaligned            taken target with bit 1 set
//   mispredict            wrong prediction on a resolved, aligned result
//   redirect_pc           correct next PC while mispredict is high
//   flush                 squash younger stages
//   taken_count, mispredict_count  saturating statistics
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic [9:0]       op_funct,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             br_valid,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic             misaligned,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int FC_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

  logic [2:0]      funct3;
  logic [6:0]      opcode;
  logic            eq, lt, ltu;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_sum;
  logic            is_ctrl;
  logic            taken_dec;
  logic [XLEN-1:0] target_dec;
  logic            misalign_dec;
  logic            mispred_dec;
  logic [XLEN-1:0] redirect_dec;
  logic            load;

  logic            valid_reg;
  logic            taken_reg;
  logic [XLEN-1:0] target_reg;
  logic            pred_reg;
  logic [XLEN-1:0] redirect_reg;
  logic            flush_reg;
  state_t          state_reg;
  logic [FC_W-1:0] fcnt_reg;
  logic [CNT_W-1:0] tcnt_reg;
  logic [CNT_W-1:0] mcnt_reg;

  assign funct3 = op_funct[9:7];
  assign opcode = op_funct[6:0];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1 (rs1_val),
    .rs2 (rs2_val),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  assign branch_target = pc + imm;
  assign jalr_sum      = rs1_val + imm;

  always_comb begin
    is_ctrl    = 1'b0;
    taken_dec  = 1'b0;
    target_dec = branch_target;
    case (opcode)
      OP_BRANCH: begin
        is_ctrl = 1'b1;
        case (funct3)
          F3_BEQ:  taken_dec = eq;
          F3_BNE:  taken_dec = ~eq;
          F3_BLT:  taken_dec = lt;
          F3_BGE:  taken_dec = ~lt;
          F3_BLTU: taken_dec = ltu;
          F3_BGEU: taken_dec = ~ltu;
          default: is_ctrl   = 1'b0;
        endcase
      end
      OP_JAL: begin
        is_ctrl   = 1'b1;
        taken_dec = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          is_ctrl    = 1'b1;
          taken_dec  = 1'b1;
          target_dec = {jalr_sum[XLEN-1:1], 1'b0};
        end
      end
      default: is_ctrl = 1'b0;
    endcase
  end

  // A misaligned taken target belongs to the trap path, so it never mispredicts.
  assign misalign_dec = taken_dec & target_dec[1];
  assign mispred_dec  = ~misalign_dec & (taken_dec != pred_taken);
  assign redirect_dec = taken_dec ? target_dec : (pc + XLEN'(4));

  // Wrong-path candidates arriving during a flush are dropped here.
  assign load = ex_valid & ~stall & (state_reg == IDLE) & is_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg    <= 1'b0;
      taken_reg    <= 1'b0;
      target_reg   <= '0;
      pred_reg     <= 1'b0;
      redirect_reg <= '0;
      flush_reg    <= 1'b0;
      state_reg    <= IDLE;
      fcnt_reg     <= '0;
      tcnt_reg     <= '0;
      mcnt_reg     <= '0;
    end else if (!stall) begin
      valid_reg <= load;
      if (load) begin
        taken_reg    <= taken_dec;
        target_reg   <= target_dec;
        pred_reg     <= pred_taken;
        redirect_reg <= redirect_dec;
      end else begin
        taken_reg    <= 1'b0;
      end

      // Counting at load time means a result held by stall is never re-counted.
      if (load && taken_dec && (tcnt_reg != {CNT_W{1'b1}}))
        tcnt_reg <= tcnt_reg + 1'b1;
      if (load && mispred_dec && (mcnt_reg != {CNT_W{1'b1}}))
        mcnt_reg <= mcnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (load && mispred_dec) begin
            state_reg <= FLUSH;
            fcnt_reg  <= FC_W'(FLUSH_DEPTH);
            flush_reg <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt_reg <= FC_W'(1)) begin
            state_reg <= IDLE;
            fcnt_reg  <= '0;
            flush_reg <= 1'b0;
          end else begin
            fcnt_reg  <= fcnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign br_valid         = valid_reg;
  assign br_taken         = taken_reg;
  assign br_target        = target_reg;
  assign misaligned       = taken_reg & target_reg[1];
  assign mispredict       = valid_reg & ~misaligned & (taken_reg != pred_reg);
  assign redirect_pc      = redirect_reg;
  assign flush            = flush_reg;
  assign taken_count      = tcnt_reg;
  assign mispredict_count = mcnt_reg;

endmodule
